// File: rtl/zet_wb_bridge.sv
// Bridges the Zet core's flat memory/IO request onto a 16-bit Wishbone classic bus.
// Odd-address word accesses are split into two byte cycles; the core stalls until done.
module zet_wb_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [19:0] cpu_adr,
    input  logic [15:0] cpu_dat_o,
    input  logic        cpu_we,
    input  logic        cpu_m_io,
    input  logic        cpu_byte,
    output logic [15:0] cpu_dat_i,
    output logic        cpu_block,
    output logic [18:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic [1:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_tga_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {StIdle, StCyc1, StCyc2, StDone} state_e;

    state_e      state_q, state_d;
    logic [19:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic        mio_q, mio_d;
    logic        byte_q, byte_d;
    logic [15:0] rdat_q, rdat_d;
    logic [18:0] wb_adr_q, wb_adr_d;
    logic [15:0] wb_dat_q, wb_dat_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_tga_q, wb_tga_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        wb_stb_q, wb_stb_d;

    logic        ack;
    logic        split;
    logic [19:0] adr_inc;

    assign ack   = wb_ack_i & wb_stb_q;
    assign split = ~byte_q & adr_q[0];

    // I/O space is only 64K, so the second half of a split wraps within 16 bits.
    always_comb begin
        adr_inc = adr_q + 20'd1;
        if (mio_q) begin
            adr_inc = {4'h0, adr_q[15:0] + 16'd1};
        end
    end

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        mio_d    = mio_q;
        byte_d   = byte_q;
        rdat_d   = rdat_q;
        wb_adr_d = wb_adr_q;
        wb_dat_d = wb_dat_q;
        wb_sel_d = wb_sel_q;
        wb_we_d  = wb_we_q;
        wb_tga_d = wb_tga_q;
        wb_cyc_d = wb_cyc_q;
        wb_stb_d = wb_stb_q;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    adr_d    = cpu_adr;
                    dat_d    = cpu_dat_o;
                    we_d     = cpu_we;
                    mio_d    = cpu_m_io;
                    byte_d   = cpu_byte;
                    wb_adr_d = cpu_adr[19:1];
                    wb_we_d  = cpu_we;
                    wb_tga_d = cpu_m_io;
                    wb_cyc_d = 1'b1;
                    wb_stb_d = 1'b1;
                    if (cpu_adr[0]) begin
                        wb_sel_d = 2'b10;
                        wb_dat_d = {cpu_dat_o[7:0], 8'h00};
                    end else if (cpu_byte) begin
                        wb_sel_d = 2'b01;
                        wb_dat_d = {8'h00, cpu_dat_o[7:0]};
                    end else begin
                        wb_sel_d = 2'b11;
                        wb_dat_d = cpu_dat_o;
                    end
                    state_d = StCyc1;
                end
            end
            StCyc1: begin
                if (ack) begin
                    if (!we_q) begin
                        if (split) begin
                            rdat_d[7:0] = wb_dat_i[15:8];
                        end else if (byte_q) begin
                            rdat_d = adr_q[0] ? {8'h00, wb_dat_i[15:8]} : {8'h00, wb_dat_i[7:0]};
                        end else begin
                            rdat_d = wb_dat_i;
                        end
                    end
                    if (split) begin
                        wb_adr_d = adr_inc[19:1];
                        wb_sel_d = 2'b01;
                        wb_dat_d = {8'h00, dat_q[15:8]};
                        state_d  = StCyc2;
                    end else begin
                        wb_cyc_d = 1'b0;
                        wb_stb_d = 1'b0;
                        state_d  = StDone;
                    end
                end
            end
            StCyc2: begin
                if (ack) begin
                    if (!we_q) begin
                        rdat_d[15:8] = wb_dat_i[7:0];
                    end
                    wb_cyc_d = 1'b0;
                    wb_stb_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            mio_q    <= 1'b0;
            byte_q   <= 1'b0;
            rdat_q   <= '0;
            wb_adr_q <= '0;
            wb_dat_q <= '0;
            wb_sel_q <= 2'b00;
            wb_we_q  <= 1'b0;
            wb_tga_q <= 1'b0;
            wb_cyc_q <= 1'b0;
            wb_stb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            mio_q    <= mio_d;
            byte_q   <= byte_d;
            rdat_q   <= rdat_d;
            wb_adr_q <= wb_adr_d;
            wb_dat_q <= wb_dat_d;
            wb_sel_q <= wb_sel_d;
            wb_we_q  <= wb_we_d;
            wb_tga_q <= wb_tga_d;
            wb_cyc_q <= wb_cyc_d;
            wb_stb_q <= wb_stb_d;
        end
    end

    assign cpu_block = cpu_req & (state_q != StDone);
    assign cpu_dat_i = rdat_q;
    assign wb_adr_o  = wb_adr_q;
    assign wb_dat_o  = wb_dat_q;
    assign wb_sel_o  = wb_sel_q;
    assign wb_we_o   = wb_we_q;
    assign wb_tga_o  = wb_tga_q;
    assign wb_cyc_o  = wb_cyc_q;
    assign wb_stb_o  = wb_stb_q;

endmodule

// File: tb/tb_zet_wb_bridge.sv
// Directed bench for zet_wb_bridge: the bench plays both core and Wishbone slave,
// with expected bus fields and read data worked out by hand.
module tb_zet_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [19:0] cpu_adr;
    logic [15:0] cpu_dat_o;
    logic        cpu_we;
    logic        cpu_m_io;
    logic        cpu_byte;
    logic [15:0] cpu_dat_i;
    logic        cpu_block;
    logic [18:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_tga_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    int total = 0;
    int bad   = 0;

    zet_wb_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_adr   (cpu_adr),
        .cpu_dat_o (cpu_dat_o),
        .cpu_we    (cpu_we),
        .cpu_m_io  (cpu_m_io),
        .cpu_byte  (cpu_byte),
        .cpu_dat_i (cpu_dat_i),
        .cpu_block (cpu_block),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_tga_o  (wb_tga_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; presents a request and advances into CYC1.
    task automatic start(input logic [19:0] adr, input logic [15:0] dat, input logic we,
                         input logic mio, input logic byt);
        cpu_req   = 1'b1;
        cpu_adr   = adr;
        cpu_dat_o = dat;
        cpu_we    = we;
        cpu_m_io  = mio;
        cpu_byte  = byt;
        @(negedge clk);
        check_eq("req.block", 32'(cpu_block), 1);
        @(posedge clk); #1;
    endtask

    // One bus half: outputs must be stable for waits+1 cycles, ack on the last one.
    task automatic bus_half(input string tag, input logic [18:0] eadr, input logic [1:0] esel,
                            input logic [15:0] edat, input logic ewe, input logic etga,
                            input logic [15:0] rdata, input int waits);
        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            check_eq({tag, ".cyc"},   32'(wb_cyc_o), 1);
            check_eq({tag, ".stb"},   32'(wb_stb_o), 1);
            check_eq({tag, ".adr"},   32'(wb_adr_o), 32'(eadr));
            check_eq({tag, ".sel"},   32'(wb_sel_o), 32'(esel));
            check_eq({tag, ".we"},    32'(wb_we_o),  32'(ewe));
            check_eq({tag, ".tga"},   32'(wb_tga_o), 32'(etga));
            check_eq({tag, ".block"}, 32'(cpu_block), 1);
            if (ewe) check_eq({tag, ".dat"}, 32'(wb_dat_o), 32'(edat));
            if (w == waits) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rdata;
            end
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0;
    endtask

    // DONE cycle: stall released with read data valid; core then drops its request.
    task automatic finish(input string tag, input logic [15:0] edat);
        @(negedge clk);
        check_eq({tag, ".done_block"}, 32'(cpu_block), 0);
        check_eq({tag, ".done_cyc"},   32'(wb_cyc_o), 0);
        check_eq({tag, ".done_stb"},   32'(wb_stb_o), 0);
        check_eq({tag, ".rdata"},      32'(cpu_dat_i), 32'(edat));
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq({tag, ".idle_block"}, 32'(cpu_block), 0);
        check_eq({tag, ".idle_stb"},   32'(wb_stb_o), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_adr   = '0;
        cpu_dat_o = '0;
        cpu_we    = 1'b0;
        cpu_m_io  = 1'b0;
        cpu_byte  = 1'b0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst.cyc",   32'(wb_cyc_o), 0);
        check_eq("rst.stb",   32'(wb_stb_o), 0);
        check_eq("rst.sel",   32'(wb_sel_o), 0);
        check_eq("rst.adr",   32'(wb_adr_o), 0);
        check_eq("rst.rdat",  32'(cpu_dat_i), 0);
        check_eq("rst.block", 32'(cpu_block), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Stray ack with no strobe must not start anything.
        wb_ack_i = 1'b1;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        @(negedge clk);
        check_eq("stray.stb", 32'(wb_stb_o), 0);
        @(posedge clk); #1;

        // Aligned memory word read, zero wait.
        start(20'h12344, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus_half("rdw", 19'h091A2, 2'b11, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 0);
        finish("rdw", 16'hBEEF);

        // Odd byte write; read data must be left untouched.
        start(20'h00101, 16'h0055, 1'b1, 1'b0, 1'b1);
        bus_half("wrb", 19'h00080, 2'b10, 16'h5500, 1'b1, 1'b0, 16'h0000, 0);
        finish("wrb", 16'hBEEF);

        // Byte reads are zero-extended from the selected lane.
        start(20'h00003, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus_half("rbo", 19'h00001, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h9A77, 0);
        finish("rbo", 16'h009A);
        start(20'h00004, 16'h0000, 1'b0, 1'b0, 1'b1);
        bus_half("rbe", 19'h00002, 2'b01, 16'h0000, 1'b0, 1'b0, 16'h7766, 0);
        finish("rbe", 16'h0066);

        // Split memory word read wrapping at the top of the 1 MB space.
        start(20'hFFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus_half("rs1", 19'h7FFFF, 2'b10, 16'h0000, 1'b0, 1'b0, 16'hAB00, 0);
        bus_half("rs2", 19'h00000, 2'b01, 16'h0000, 1'b0, 1'b0, 16'h00CD, 0);
        finish("rs", 16'hCDAB);

        // Split I/O word write wrapping at 64K.
        start(20'h0FFFF, 16'h1234, 1'b1, 1'b1, 1'b0);
        bus_half("ws1", 19'h07FFF, 2'b10, 16'h3400, 1'b1, 1'b1, 16'h0000, 0);
        bus_half("ws2", 19'h00000, 2'b01, 16'h0012, 1'b1, 1'b1, 16'h0000, 0);
        finish("ws", 16'hCDAB);

        // Wait states; request inputs wiggle mid-cycle and must be ignored.
        start(20'h00200, 16'h0000, 1'b0, 1'b0, 1'b0);
        cpu_adr  = 20'hABCDE;
        cpu_we   = 1'b1;
        cpu_m_io = 1'b1;
        bus_half("wait", 19'h00100, 2'b11, 16'h0000, 1'b0, 1'b0, 16'h1357, 3);
        finish("wait", 16'h1357);

        // Reset while in the second half of a split read.
        start(20'h00001, 16'h0000, 1'b0, 1'b0, 1'b0);
        bus_half("rr1", 19'h00000, 2'b10, 16'h0000, 1'b0, 1'b0, 16'hEE00, 0);
        @(negedge clk);
        check_eq("rr2.stb", 32'(wb_stb_o), 1);
        check_eq("rr2.sel", 32'(wb_sel_o), 32'h1);
        check_eq("rr2.adr", 32'(wb_adr_o), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rrst.cyc",   32'(wb_cyc_o), 0);
        check_eq("rrst.stb",   32'(wb_stb_o), 0);
        check_eq("rrst.sel",   32'(wb_sel_o), 0);
        check_eq("rrst.rdat",  32'(cpu_dat_i), 0);
        check_eq("rrst.block", 32'(cpu_block), 1);
        cpu_req = 1'b0;
        #1;
        check_eq("rrst.block_lo", 32'(cpu_block), 0);
        cpu_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus_half("rre1", 19'h00000, 2'b10, 16'h0000, 1'b0, 1'b0, 16'h1100, 0);
        bus_half("rre2", 19'h00001, 2'b01, 16'h0000, 1'b0, 1'b0, 16'h0022, 0);
        finish("rre", 16'h2211);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zet_wb_bridge.md
Name: zet_wb_bridge

Overview:
- Memory/I-O responder for the Zet execution stage.
- Accepts the core's flat request (20-bit address, write data, we, m_io, byte/word) and turns it into Wishbone classic cycles on a 16-bit data bus.
- Holds the core stalled via `cpu_block` until the cycle completes, then returns the read data.
- Word accesses at odd addresses are split into two byte cycles.

Parameters:
- None.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous reset, active-high.
- `cpu_req` input 1: core has a valid memory/IO operation this cycle; held high until `cpu_block` is seen low.
- `cpu_adr` input 20: byte address from the core.
- `cpu_dat_o` input 16: write data from the core; low byte is used for byte ops.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_m_io` input 1: 1 = I/O space, 0 = memory.
- `cpu_byte` input 1: 1 = byte operation, 0 = word.
- `cpu_dat_i` output 16: read data returned to the core (memout).
- `cpu_block` output 1: stall to the core.
- `wb_adr_o` output 19: word address, bits [19:1].
- `wb_dat_o` output 16: bus write data.
- `wb_dat_i` input 16: bus read data.
- `wb_sel_o` output 2: byte lane selects; bit 0 = even byte, bit 1 = odd byte.
- `wb_we_o` output 1: bus write enable.
- `wb_tga_o` output 1: I/O tag (copy of latched m_io).
- `wb_cyc_o` output 1: Wishbone cycle.
- `wb_stb_o` output 1: Wishbone strobe.
- `wb_ack_i` input 1: Wishbone acknowledge.

Behaviour:
- Reset (synchronous, any state): next edge enters IDLE.
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_tga_o` = 0.
  - `wb_sel_o` = 2'b00; `wb_adr_o`, `wb_dat_o`, `cpu_dat_i` = 0.
  - Any in-flight bus cycle is abandoned; no second half is issued.
- `cpu_block` is combinational: `cpu_req & (state != DONE)`. It is low whenever `cpu_req` is low.
- IDLE:
  - If `cpu_req`, latch A = `cpu_adr`, D, we, m_io, byte; go to CYC1.
  - Drive cyc/stb/we/tga/adr/sel/dat from the latched values (all bus outputs registered).
- Address wrap:
  - Memory: A+1 computed modulo 2^20.
  - I/O: A+1 computed modulo 2^16, with bits [19:16] forced to 0.
- CYC1 lane mapping:
  - Byte, A[0]=0: sel=01, dat={8'h00,D[7:0]}.
  - Byte, A[0]=1: sel=10, dat={D[7:0],8'h00}.
  - Word, A[0]=0: sel=11, dat=D.
  - Word, A[0]=1: sel=10, dat={D[7:0],8'h00}, first half of a split.
  - `wb_adr_o` = A[19:1].
- CYC1 on `wb_ack_i`, capturing read data:
  - Byte: selected lane → `cpu_dat_i` = {8'h00, byte} (zero-extended).
  - Aligned word: `cpu_dat_i` = `wb_dat_i`.
  - Split: captured `wb_dat_i[15:8]` goes to `cpu_dat_i[7:0]`.
- CYC1 next state on ack:
  - Split word: go to CYC2. cyc/stb stay high; adr=(A+1)[19:1]; sel=01; dat={8'h00,D[15:8]}.
  - Otherwise: go to DONE and drop cyc/stb.
- CYC2 on `wb_ack_i`: `cpu_dat_i[15:8]` = `wb_dat_i[7:0]`; go to DONE, dropping cyc/stb.
- DONE: lasts one cycle; `cpu_block` is low and `cpu_dat_i` is valid; go to IDLE.
  - `cpu_req` sampled high in IDLE after DONE starts a new transaction (back-to-back allowed).
- Ack handling:
  - `wb_ack_i` is ignored unless `wb_stb_o`=1.
  - A wait of any length (ack low) holds all bus outputs stable.
- Latency with zero-wait-state slave:
  - Aligned: req seen at cycle 0 → stb cycles 1 → `cpu_block` low in cycle 2.
  - Split: `cpu_block` low in cycle 3.
- `cpu_dat_i` holds its value outside DONE until the next read captures. Writes do not modify it.
- Request inputs are only sampled in IDLE; changes during CYC1/CYC2 are ignored.

Test Plan:
- Aligned word read, mem, A=0x12344, slave data 0xBEEF, ack same cycle as stb.
  - Expect adr=0x091A2, sel=11, tga=0, one bus cycle.
  - `cpu_block` low in cycle 2 with `cpu_dat_i`=0xBEEF.
- Odd byte write, A=0x00101, D=0x0055.
  - Expect sel=10, `wb_dat_o`=0x5500, we=1, adr=0x00080, single cycle.
- Odd word read, A=0xFFFFF, mem, first ack data 0xAB00, second 0x00CD.
  - Expect adr 0x7FFFF then 0x00000, sel 10 then 01.
  - `cpu_dat_i`=0xCDAB; `cpu_block` low in cycle 3.
- Odd word I/O write, A=0x0FFFF, D=0x1234, m_io=1.
  - Expect tga=1; first adr 0x07FFF sel=10 dat=0x3400; second adr 0x00000 sel=01 dat=0x0012.
- Wait states: ack delayed 3 cycles on an aligned read.
  - Outputs stable throughout; `cpu_block` high until the cycle after ack.
- `rst` asserted in CYC2 of a split read.
  - Next edge: cyc/stb=0, sel=00, state IDLE, `cpu_dat_i`=0, `cpu_block` mirrors `cpu_req`.
  - After `rst` is released with `cpu_req` still high, a fresh transaction restarts from CYC1.
